if_id_fetch_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register for the pipelined LEGv8 CPU.
- Sits directly upstream of the instruction decoder and replaces the single-cycle PC incrementor.
- Owns the PC, drives the instruction-memory address and registers the fetched instruction with its PC.
- Branches are resolved in ID; the stage applies the redirect one cycle later. An optional flush of the wrong-path instruction is selectable by parameter.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/br_target_calc.sv | 36 +++
 rtl/if_id_fetch_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared constants and IF/ID register type for the LEGv8 pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int c_INSTR_W  = 32;
    localparam int c_PC_W_MAX = 64;
    localparam int c_PC_INC   = 4;

    localparam logic [c_INSTR_W-1:0] c_NOP = 32'hD503201F;

    typedef struct packed {
        logic [c_INSTR_W-1:0]  instr;
        logic [c_PC_W_MAX-1:0] pc;
        logic                  valid;
    } fetch_reg_t;

endpackage

`default_nettype wire

// File: rtl/br_target_calc.sv
// ============================================================================
// Module   : br_target_calc
// Purpose  : Branch target = pc + (sign-extended word offset << 2), wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module br_target_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_uncond_br,
    input  logic [18:0]     i_cond_addr19,
    input  logic [25:0]     i_br_addr26,
    output logic [PC_W-1:0] o_target
);

    logic [PC_W-1:0] w_offset;

    always_comb begin
        w_offset = '0;
        if (i_uncond_br) begin
            w_offset = {{(PC_W-26){i_br_addr26[25]}}, i_br_addr26};
        end else begin
            w_offset = {{(PC_W-19){i_cond_addr19[18]}}, i_cond_addr19};
        end
    end

    // Word offset to byte offset; top two bits of the offset fall off by design.
    assign o_target = i_pc + {w_offset[PC_W-3:0], 2'b00};

endmodule

`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// Module   : if_id_fetch_stage
// Purpose  : PC register, instruction fetch and IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W       = 64,
    parameter bit              DELAY_SLOT = 1'b1,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic                 uncond_br,
    input  logic [18:0]          cond_addr19,
    input  logic [25:0]          br_addr26,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [c_INSTR_W-1:0] imem_instr,
    output logic [c_INSTR_W-1:0] id_instruction,
    output logic [PC_W-1:0]      id_pc,
    output logic                 id_valid
);

    logic [PC_W-1:0] r_pc;
    fetch_reg_t      r_ifid;

    logic [PC_W-1:0] w_id_pc;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_next_seq;
    fetch_reg_t      w_fetch_seq;
    fetch_reg_t      w_fetch_slot;

    assign w_id_pc       = r_ifid.pc[PC_W-1:0];
    assign w_pc_next_seq = r_pc + PC_W'(c_PC_INC);
    assign w_fetch_seq   = '{instr: imem_instr, pc: c_PC_W_MAX'(r_pc), valid: 1'b1};

    // Branches resolve in ID, so the target is relative to the instruction held in IF/ID.
    br_target_calc #(
        .PC_W (PC_W)
    ) u_br_target_calc (
        .i_pc          (w_id_pc),
        .i_uncond_br   (uncond_br),
        .i_cond_addr19 (cond_addr19),
        .i_br_addr26   (br_addr26),
        .o_target      (w_target)
    );

    generate
        if (DELAY_SLOT) begin : g_delay_slot
            assign w_fetch_slot = w_fetch_seq;
        end else begin : g_squash_slot
            assign w_fetch_slot = '{instr: c_NOP, pc: c_PC_W_MAX'(r_pc), valid: 1'b0};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc   <= RESET_PC;
            r_ifid <= '{instr: c_NOP, pc: '0, valid: 1'b0};
        end else if (!stall) begin
            if (br_taken) begin
                r_pc   <= w_target;
                r_ifid <= w_fetch_slot;
            end else begin
                r_pc   <= w_pc_next_seq;
                r_ifid <= w_fetch_seq;
            end
        end
    end

    assign imem_addr      = r_pc;
    assign id_instruction = r_ifid.instr;
    assign id_pc          = w_id_pc;
    assign id_valid       = r_ifid.valid;

endmodule

`default_nettype wire
